// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller.
// A single full-adder cell is reused once per clock, LSB first, over WIDTH
// cycles. Subtraction is a + ~b + 1. Results are published only on completion.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
  logic               ovf_q;

  logic               fa_s;
  logic               fa_co;

  // The one full-adder cell, fed from the operand LSBs and the carry register.
  always_comb begin
    fa_s   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_co  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
    work_d = {fa_s, work_q[WIDTH-1:1]};
  end

  // Control FSM plus datapath registers, all updated on the rising edge.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them see the pre-edge
    // values of each other; blocking = would make ordering change behaviour.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // sub and c_in are captured here only; the run never looks back
            // at the input ports.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            cnt_q   <= '0;
            work_q  <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end

        RUN: begin
          work_q  <= work_d;
          carry_q <= fa_co;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // carry_q is the carry into the MSB on this final step.
            sum_q   <= work_d;
            c_out_q <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            state_q <= DONE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8.
// Expected results are queued when an operation is launched and compared
// by a monitor when the completion pulse appears.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  vec_t sb_q[$];
  vec_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic written directly from the two's-complement definition.
  function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vc, input logic vs);
    vec_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb          = vs ? ~vb : vb;
    full        = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, (vs ? 1'b1 : vc)};
    r.a         = va;
    r.b         = vb;
    r.c_in      = vc;
    r.sub       = vs;
    r.e_sum     = full[W-1:0];
    r.e_cout    = full[W];
    r.e_ovf     = (va[W-1] == bb[W-1]) && (full[W-1] != va[W-1]);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected done pulse", 64'(done), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("result sum",      64'(sum),      64'(mon_e.e_sum));
        check("result c_out",    64'(c_out),    64'(mon_e.e_cout));
        check("result overflow", 64'(overflow), 64'(mon_e.e_ovf));
      end
    end
  end

  // Drive a start request with the given operands; caller is at a negedge.
  task automatic launch(input vec_t v);
    a     = v.a;
    b     = v.b;
    c_in  = v.c_in;
    sub   = v.sub;
    start = 1'b1;
    sb_q.push_back(v);
  endtask

  // Follow one operation to its done cycle; returns at the done negedge.
  task automatic wait_done(input bit hold, input string nm);
    int           nbusy;
    bit           seen;
    bit           stable;
    logic [W-1:0] prev_sum;
    nbusy    = 0;
    seen     = 1'b0;
    stable   = 1'b1;
    prev_sum = sum;
    @(negedge clk);
    start = hold;
    // Scramble the ports; the operation in flight must not notice.
    a     = W'($urandom);
    b     = W'($urandom);
    c_in  = 1'($urandom);
    sub   = 1'($urandom);
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) begin
        nbusy++;
        if (sum !== prev_sum) stable = 1'b0;
      end
      if (nbusy >= W) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({nm, " busy cycles"}, 64'(nbusy), 64'(W));
    check({nm, " done seen"}, 64'(seen), 64'(1));
    check({nm, " sum held while busy"}, 64'(stable), 64'(1));
  endtask

  // Done must be a single-cycle pulse with nothing queued behind it.
  task automatic after_done(input string nm);
    @(negedge clk);
    check({nm, " idle after done"}, 64'({busy, done}), 64'(0));
  endtask

  vec_t vt[10];
  vec_t v;

  initial begin
    // Constant vectors: {a, b, c_in, sub, sum, c_out, overflow}
    vt[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vt[7] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[9] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b1;   // reset must win over start
    a     = 8'h12;
    b     = 8'h34;
    c_in  = 1'b0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy",     64'(busy),     64'(0));
    check("reset done",     64'(done),     64'(0));
    check("reset sum",      64'(sum),      64'(0));
    check("reset c_out",    64'(c_out),    64'(0));
    check("reset overflow", 64'(overflow), 64'(0));
    start = 1'b0;
    rst   = 1'b0;

    // Abort: reset on the 4th RUN cycle, no done pulse, sum untouched.
    @(negedge clk);
    a     = 8'h33;
    b     = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy before reset", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("abort busy cleared", 64'(busy), 64'(0));
    check("abort no done",      64'(done), 64'(0));
    check("abort sum kept",     64'(sum),  64'(0));
    rst = 1'b0;
    // Fresh start on the first edge after reset release.
    launch(vt[0]);
    wait_done(1'b0, "post-abort");
    after_done("post-abort");

    // Table of constant vectors.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      launch(vt[i]);
      wait_done(1'b0, $sformatf("vec%0d", i));
      after_done($sformatf("vec%0d", i));
    end

    // start held high for the whole run: ignored, not queued.
    @(negedge clk);
    launch(vt[2]);
    wait_done(1'b1, "held start");
    after_done("held start");

    // Back-to-back: new start accepted in the DONE cycle.
    @(negedge clk);
    launch(vt[4]);
    wait_done(1'b0, "b2b first");
    launch(vt[5]);
    wait_done(1'b0, "b2b second");
    after_done("b2b second");

    // A few model-checked random operations.
    for (int i = 0; i < 6; i++) begin
      v = model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      launch(v);
      wait_done(1'b0, $sformatf("rand%0d", i));
      after_done($sformatf("rand%0d", i));
    end

    repeat (2) @(negedge clk);
    check("scoreboard drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port c_in, input, 1 bit: carry-in for add mode.
REQ-008 The block SHALL have port sub, input, 1 bit: 1 = compute a - b, 0 = compute a + b + c_in.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result of the last completed operation.
REQ-012 The block SHALL have port c_out, output, 1 bit: carry out of the MSB of the last result.
REQ-013 The block SHALL have port overflow, output, 1 bit: two's-complement overflow of the last result.

Function
REQ-014 The block SHALL compute with exactly one 1-bit full-adder cell (s = x^y^c, co = xy|xc|yc), reused once per cycle, LSB first.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE, all registered.
REQ-016 In IDLE or DONE with start=1, the block SHALL latch a, latch b (or ~b when sub=1), set the carry register to c_in (or 1 when sub=1), clear the bit counter and enter RUN.
REQ-017 The sub and c_in values SHALL be sampled only on the start edge; later changes on a, b, c_in or sub SHALL NOT affect an operation in progress.
REQ-018 In RUN, each edge SHALL process the current LSB of the operand shift registers: shift the sum bit in at the working-register MSB, update the carry register, shift both operands right and increment the counter.
REQ-019 When the counter reaches WIDTH-1 in RUN, that edge SHALL process the final bit and enter DONE.
REQ-020 Latency: with start sampled at edge E0, the WIDTH bits SHALL be processed at edges E1..EWIDTH, and done SHALL be high for exactly the cycle following EWIDTH.
REQ-021 busy SHALL equal (state==RUN): high for exactly WIDTH cycles per operation.
REQ-022 done SHALL equal (state==DONE); DONE with start=0 SHALL return to IDLE on the next edge.
REQ-023 start asserted during RUN SHALL be ignored; it SHALL NOT be queued.
REQ-024 start asserted during DONE SHALL be accepted: done is still high that cycle and the next state is RUN, so back-to-back operations have zero idle cycles.
REQ-025 sum, c_out and overflow SHALL update only at the edge that enters DONE and SHALL hold until the next completion; intermediate partial sums SHALL NOT be visible.
REQ-026 c_out SHALL be the carry out of bit WIDTH-1; in sub mode c_out=1 means no borrow (a >= b unsigned).
REQ-027 overflow SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-028 Arithmetic SHALL be modulo 2^WIDTH, with no saturation.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, sum, c_out, overflow, the counter, the carry register and the operand registers to 0.
REQ-030 Reset SHALL take priority over start.
REQ-031 Reset during RUN SHALL abort the operation, with no done pulse and no result update.
REQ-032 The block SHALL accept a new start on the first edge after rst deasserts.

Verification (WIDTH=8)
REQ-033 A bench SHALL cover: start with a=0x0F, b=0x01, c_in=0, sub=0 -> busy for 8 cycles, then done for 1 cycle, sum=0x10, c_out=0, overflow=0.
REQ-034 A bench SHALL cover: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0; and a=0x7F, b=0x01 -> sum=0x80, c_out=0, overflow=1.
REQ-035 A bench SHALL cover: sub=1, a=0x05, b=0x07 -> sum=0xFE, c_out=0, overflow=0; and sub=1, a=0x80, b=0x01 -> sum=0x7F, c_out=1, overflow=1.
REQ-036 A bench SHALL cover exhaustive full-adder corners with a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1, overflow=0; and a=0, b=0, c_in=1 -> sum=0x01.
REQ-037 A bench SHALL cover: rst pulsed on the 4th RUN cycle -> busy=0 next cycle, no done pulse, sum stays 0x00; then a fresh start completes correctly.
REQ-038 A bench SHALL cover: start held high in RUN (ignored, result unchanged), and start asserted in the DONE cycle with new operands -> second result after exactly 8 more busy cycles.
